// File: rtl/trigsrc_if.sv
// Valid/ready/data stream interface shared by trigsrc and its neighbours.
// The producer drives valid and data; the consumer drives ready.
interface dti #(
  parameter int W = 16
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/trigsrc.sv
// Turns a handshaked data stream into trigger update words {flag, data}, with an
// optional idle-timeout invalidate. Define TRIGSRC_DROP_CNT_EN to add drop_cnt.
module trigsrc #(
  parameter int DIN     = 16,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  dti.consumer             din,
  dti.producer             dout
`ifdef TRIGSRC_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0] drop_cnt
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  localparam bit TO_EN = (TIMEOUT != 0);
  // Compared against only when the timeout is enabled, so 0 is a safe filler.
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [DIN-1:0]   last_data_reg, last_data_next;
  logic             pend_valid_reg, pend_valid_next;
  logic [DIN:0]     pend_word_reg, pend_word_next;

  logic in_evt;
  logic to_evt;
  logic any_evt;

  assign din.ready = 1'b1;

  assign in_evt  = din.valid;
  assign to_evt  = TO_EN && (state_reg == ARMED) && !in_evt && (cnt_reg == TO_LAST);
  assign any_evt = in_evt || to_evt;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_data_next  = last_data_reg;
    pend_valid_next = pend_valid_reg;
    pend_word_next  = pend_word_reg;

    if (in_evt) begin
      // Input wins over a coinciding timeout: re-arm and restart the count.
      state_next      = ARMED;
      cnt_next        = '0;
      last_data_next  = din.data;
      pend_word_next  = {1'b1, din.data};
      pend_valid_next = 1'b1;
    end else if (to_evt) begin
      state_next      = IDLE;
      cnt_next        = '0;
      pend_word_next  = {1'b0, last_data_reg};
      pend_valid_next = 1'b1;
    end else begin
      if (pend_valid_reg && dout.ready) begin
        pend_valid_next = 1'b0;
      end
      if (state_reg == ARMED) begin
        if (cnt_reg != '1) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end else begin
        cnt_next = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      last_data_reg  <= '0;
      pend_valid_reg <= 1'b0;
      pend_word_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      last_data_reg  <= last_data_next;
      pend_valid_reg <= pend_valid_next;
      pend_word_reg  <= pend_word_next;
    end
  end

  assign dout.valid = pend_valid_reg;
  assign dout.data  = pend_word_reg;

`ifdef TRIGSRC_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  // A drop is an event landing on a word the consumer has not taken yet.
  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (pend_valid_reg && !dout.ready && any_evt && (drop_cnt_reg != '1)) begin
      drop_cnt_next = drop_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else begin
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule
